// File: rtl/and_add_flag_unit_pkg.sv
// Shared definitions for the AND/ADD execute slice: widths, flag bit positions,
// operand-size and operation codes.
package and_add_flag_unit_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned FlagW = 6;

    localparam int unsigned FlagCf = 0;
    localparam int unsigned FlagPf = 1;
    localparam int unsigned FlagAf = 2;
    localparam int unsigned FlagZf = 3;
    localparam int unsigned FlagSf = 4;
    localparam int unsigned FlagOf = 5;

    // Code 2'b11 is not architecturally defined and is handled like 32-bit.
    typedef enum logic [1:0] {
        Sz8     = 2'b00,
        Sz16    = 2'b01,
        Sz32    = 2'b10,
        Sz32Alt = 2'b11
    } op_size_e;

    typedef enum logic {
        OpAnd = 1'b0,
        OpAdd = 1'b1
    } op_e;

    function automatic logic even_parity(input logic [7:0] byte_i);
        return ~^byte_i;
    endfunction

endpackage

// File: rtl/and_add_flag_unit_flag_calc.sv
// Combinational x86-style status flag generation for the selected operand size.
module and_add_flag_unit_flag_calc
    import and_add_flag_unit_pkg::*;
(
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  logic [DataW-1:0] s_i,
    input  logic             c4_i,
    input  logic             c8_i,
    input  logic             c16_i,
    input  logic             c32_i,
    input  op_size_e         op_size_i,
    input  logic             is_add_i,
    output logic [FlagW-1:0] flags_o
);

    logic a_msb;
    logic b_msb;
    logic s_msb;
    logic slice_zero;
    logic size_carry;

    always_comb begin
        a_msb      = a_i[31];
        b_msb      = b_i[31];
        s_msb      = s_i[31];
        slice_zero = (s_i == '0);
        size_carry = c32_i;
        case (op_size_i)
            Sz8: begin
                a_msb      = a_i[7];
                b_msb      = b_i[7];
                s_msb      = s_i[7];
                slice_zero = (s_i[7:0] == 8'h00);
                size_carry = c8_i;
            end
            Sz16: begin
                a_msb      = a_i[15];
                b_msb      = b_i[15];
                s_msb      = s_i[15];
                slice_zero = (s_i[15:0] == 16'h0000);
                size_carry = c16_i;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        flags_o         = '0;
        // Parity always looks at the low byte, whatever the operand size.
        flags_o[FlagPf] = even_parity(s_i[7:0]);
        flags_o[FlagZf] = slice_zero;
        flags_o[FlagSf] = s_msb;
        if (is_add_i) begin
            flags_o[FlagCf] = size_carry;
            flags_o[FlagAf] = c4_i;
            flags_o[FlagOf] = (a_msb == b_msb) && (s_msb != a_msb);
        end
    end

    // Only the sign bits of the operands matter for overflow.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_i[30:16], a_i[14:8], a_i[6:0],
                                   b_i[30:16], b_i[14:8], b_i[6:0]};

endmodule

// File: rtl/and_add_flag_unit.sv
// Execute-stage slice: 32-bit AND or ADD with sized status flags, one-cycle
// registered result, flags and valid.
module and_add_flag_unit
    import and_add_flag_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             op_sel,
    input  logic [1:0]       op_size,
    input  logic [DataW-1:0] sr1,
    input  logic [DataW-1:0] sr2,
    output logic [DataW-1:0] res,
    output logic [FlagW-1:0] flags,
    output logic             valid_out
);

    logic [DataW-1:0] res_d, res_q;
    logic [FlagW-1:0] flags_d, flags_q;
    logic             valid_d, valid_q;

    logic [DataW-1:0] and_res;
    logic [DataW-1:0] add_res;
    logic             c4, c8, c16, c32;
    logic             is_add;

    assign and_res = sr1 & sr2;
    assign is_add  = (op_e'(op_sel) == OpAdd);

    // Adder split at the flag boundaries so the intermediate carries are visible.
    logic [4:0]  sum_n0;
    logic [4:0]  sum_n1;
    logic [8:0]  sum_b1;
    logic [16:0] sum_hw;

    always_comb begin
        sum_n0  = {1'b0, sr1[3:0]} + {1'b0, sr2[3:0]};
        c4      = sum_n0[4];
        sum_n1  = {1'b0, sr1[7:4]} + {1'b0, sr2[7:4]} + {4'b0, c4};
        c8      = sum_n1[4];
        sum_b1  = {1'b0, sr1[15:8]} + {1'b0, sr2[15:8]} + {8'b0, c8};
        c16     = sum_b1[8];
        sum_hw  = {1'b0, sr1[31:16]} + {1'b0, sr2[31:16]} + {16'b0, c16};
        c32     = sum_hw[16];
        add_res = {sum_hw[15:0], sum_b1[7:0], sum_n1[3:0], sum_n0[3:0]};
    end

    always_comb begin
        res_d   = is_add ? add_res : and_res;
        valid_d = valid_in;
    end

    and_add_flag_unit_flag_calc u_flag_calc (
        .a_i       (sr1),
        .b_i       (sr2),
        .s_i       (res_d),
        .c4_i      (c4),
        .c8_i      (c8),
        .c16_i     (c16),
        .c32_i     (c32),
        .op_size_i (op_size_e'(op_size)),
        .is_add_i  (is_add),
        .flags_o   (flags_d)
    );

    // Captures every edge; valid only tags the data, it never gates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign res       = res_q;
    assign flags     = flags_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_and_add_flag_unit.sv
// Scoreboard bench for and_add_flag_unit: directed vectors, size/op sweeps,
// random traffic and an asynchronous mid-stream reset.
module tb_and_add_flag_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        op_sel;
    logic [1:0]  op_size;
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic [31:0] res;
    logic [5:0]  flags;
    logic        valid_out;

    and_add_flag_unit dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .op_sel    (op_sel),
        .op_size   (op_size),
        .sr1       (sr1),
        .sr2       (sr2),
        .res       (res),
        .flags     (flags),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  flags;
        logic        valid;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: flags derived from wide sums and masks.
    function automatic exp_t model(input logic op, input logic [1:0] sz, input logic [31:0] a,
                                   input logic [31:0] b, input logic v);
        exp_t        e;
        logic [32:0] s33;
        logic [32:0] lo4, lo8, lo16;
        logic [63:0] mask;
        int          w;
        int          msb;
        logic        cf;
        s33  = {1'b0, a} + {1'b0, b};
        lo4  = {1'b0, a & 32'h0000000F} + {1'b0, b & 32'h0000000F};
        lo8  = {1'b0, a & 32'h000000FF} + {1'b0, b & 32'h000000FF};
        lo16 = {1'b0, a & 32'h0000FFFF} + {1'b0, b & 32'h0000FFFF};
        w    = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        msb  = w - 1;
        mask = (64'd1 << w) - 64'd1;
        e.res   = op ? s33[31:0] : (a & b);
        e.valid = v;
        e.flags = '0;
        e.flags[1] = ~^e.res[7:0];
        e.flags[3] = (({32'b0, e.res} & mask) == 64'd0);
        e.flags[4] = e.res[msb];
        if (op) begin
            cf = (w == 8) ? lo8[8] : (w == 16) ? lo16[16] : s33[32];
            e.flags[0] = cf;
            e.flags[2] = lo4[4];
            e.flags[5] = (a[msb] == b[msb]) && (e.res[msb] != a[msb]);
        end
        return e;
    endfunction

    task automatic drive(input logic op, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        @(negedge clk);
        op_sel   = op;
        op_size  = sz;
        sr1      = a;
        sr2      = b;
        valid_in = v;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_res"}, res, e.res);
            check_eq({tag, "_flags"}, {26'b0, flags}, {26'b0, e.flags});
            check_eq({tag, "_valid"}, {31'b0, valid_out}, {31'b0, e.valid});
        end
    endtask

    typedef struct {
        string       tag;
        logic        op;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [5:0]  flags;
    } vec_t;

    vec_t dir[7];

    initial begin
        dir[0] = '{"and32_zero", 1'b0, 2'b10, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 6'h0A};
        dir[1] = '{"add8_of",    1'b1, 2'b00, 32'h0000007F, 32'h00000001, 32'h00000080, 6'h34};
        dir[2] = '{"add32_wrap", 1'b1, 2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 6'h0F};
        dir[3] = '{"add16_noc",  1'b1, 2'b01, 32'h000000FF, 32'h00000001, 32'h00000100, 6'h06};
        dir[4] = '{"and8_unmsk", 1'b0, 2'b00, 32'h12345680, 32'hFFFFFF80, 32'h12345680, 6'h10};
        dir[5] = '{"add11_wrap", 1'b1, 2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 6'h0F};
        dir[6] = '{"add8_cf",    1'b1, 2'b00, 32'h000000FF, 32'h00000001, 32'h00000100, 6'h0F};

        rst      = 1'b1;
        valid_in = 1'b1;
        op_sel   = 1'b1;
        op_size  = 2'b10;
        sr1      = 32'h12345678;
        sr2      = 32'h11111111;
        #12;
        check_eq("reset_res", res, 32'h0);
        check_eq("reset_flags", {26'b0, flags}, 32'h0);
        check_eq("reset_valid", {31'b0, valid_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (dir[i]) begin
            drive(dir[i].op, dir[i].sz, dir[i].a, dir[i].b, 1'b1);
            sb_q.push_back('{res: dir[i].res, flags: dir[i].flags, valid: 1'b1});
            collect(dir[i].tag);
        end

        // Same operands across every op/size, including the undefined size code.
        for (int op = 0; op < 2; op++) begin
            for (int sz = 0; sz < 4; sz++) begin
                drive(op[0], sz[1:0], 32'h80008080, 32'h80808080, sz[0]);
                sb_q.push_back(model(op[0], sz[1:0], 32'h80008080, 32'h80808080, sz[0]));
                collect("sweep");
            end
        end

        for (int n = 0; n < 40; n++) begin
            logic        op;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] b;
            logic        v;
            op = 1'($urandom_range(1, 0));
            sz = 2'($urandom_range(3, 0));
            a  = $urandom();
            b  = $urandom();
            v  = 1'($urandom_range(1, 0));
            drive(op, sz, a, b, v);
            sb_q.push_back(model(op, sz, a, b, v));
            collect("rand");
        end

        // Asynchronous reset between edges after a nonzero capture.
        drive(1'b1, 2'b00, 32'h0000007F, 32'h00000001, 1'b1);
        sb_q.push_back('{res: 32'h00000080, flags: 6'h34, valid: 1'b1});
        collect("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_res", res, 32'h0);
        check_eq("mid_rst_flags", {26'b0, flags}, 32'h0);
        check_eq("mid_rst_valid", {31'b0, valid_out}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("held_rst_valid", {31'b0, valid_out}, 32'h0);
        check_eq("held_rst_res", res, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 2'b10, 32'hFFFF0000, 32'h0000FFFF, 1'b1);
        sb_q.push_back('{res: 32'h00000000, flags: 6'h0A, valid: 1'b1});
        collect("post_rst");

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
